// File: rtl/multi_slice_add_sequencer.sv
// Sequential WIDTH-bit adder front/back end around an external combinational 16-bit adder.
// Issues one slice per cycle, low slice first, rippling the carry through a register.
module multi_slice_add_sequencer #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NSLICE = WIDTH / 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic [15:0]      add_a,
    output logic [15:0]      add_b,
    output logic             add_cin,
    output logic             add_p0,
    input  logic [15:0]      add_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int unsigned SW   = 16;
    localparam int unsigned IDXW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                      r_state;
    logic [WIDTH-1:0]            r_a;
    logic [WIDTH-1:0]            r_b;
    logic                        r_carry;
    logic [IDXW-1:0]             r_idx;
    logic                        r_in_ready;
    logic                        r_out_valid;
    logic [NSLICE-1:0][SW-1:0]   r_sum;
    logic                        r_cout;
    logic                        r_ovf;

    logic [NSLICE-1:0][SW-1:0]   w_a_sl;
    logic [NSLICE-1:0][SW-1:0]   w_b_sl;
    logic                        w_a15;
    logic                        w_b15;
    logic                        w_s15;
    logic                        w_c;
    logic                        w_last;

    assign w_a_sl  = r_a;
    assign w_b_sl  = r_b;
    assign add_a   = w_a_sl[r_idx];
    assign add_b   = w_b_sl[r_idx];
    assign add_cin = r_carry;
    assign add_p0  = 1'b0;

    // Carry out of the slice recovered from the operand MSBs and the sum MSB.
    assign w_a15  = add_a[SW-1];
    assign w_b15  = add_b[SW-1];
    assign w_s15  = add_sum[SW-1];
    assign w_c    = (w_a15 & w_b15) | ((w_a15 | w_b15) & ~w_s15);
    assign w_last = (r_idx == IDXW'(NSLICE - 1));

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_sum;
    assign out_cout  = r_cout;
    assign out_ovf   = r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a        <= in_a;
                        r_b        <= in_b;
                        r_carry    <= in_cin;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum[r_idx] <= add_sum;
                    r_carry      <= w_c;
                    if (w_last) begin
                        r_cout      <= w_c;
                        r_ovf       <= (w_a15 == w_b15) & (w_s15 != w_a15);
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_idx <= r_idx + IDXW'(1);
                    end
                end
                S_DONE: begin
                    // Re-accept only from IDLE, i.e. the cycle after this handshake.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_slice_add_sequencer.sv
// Directed bench for multi_slice_add_sequencer at WIDTH=32 with a behavioural 16-bit adder.
module tb_multi_slice_add_sequencer;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic [15:0]      add_a;
    logic [15:0]      add_b;
    logic             add_cin;
    logic             add_p0;
    logic [15:0]      add_sum;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    int errors = 0;
    int checks = 0;

    multi_slice_add_sequencer #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_p0(add_p0),
        .add_sum(add_sum),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
    );

    // External combinational adder
    assign add_sum = add_a + add_b + {15'd0, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one operand pair for one cycle, then wait (bounded) for out_valid.
    task automatic start_and_wait(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic cin, output int lat, output logic timed_out);
        in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin;
        step();
        in_valid = 1'b0;
        lat = 1;
        timed_out = 1'b0;
        step();
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        if (!out_valid) timed_out = 1'b1;
        else lat++;
        lat = lat - 1;
    endtask

    task automatic test_reset();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_sum !== 32'h0) begin errors++; $display("FAIL reset_out_sum got=%h exp=0", out_sum); end
        checks++; if ({out_cout, out_ovf} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {out_cout, out_ovf}); end
        checks++; if (add_p0 !== 1'b0) begin errors++; $display("FAIL add_p0 got=%b exp=0", add_p0); end
    endtask

    task automatic test_vectors();
        logic [WIDTH-1:0] va [6];
        logic [WIDTH-1:0] vb [6];
        logic             vc [6];
        logic [WIDTH-1:0] es [6];
        logic             ec [6];
        logic             eo [6];
        int               lat;
        logic             to;
        va[0] = 32'h0000_1234; vb[0] = 32'h0000_0001; vc[0] = 0; es[0] = 32'h0000_1235; ec[0] = 0; eo[0] = 0;
        va[1] = 32'h0000_FFFF; vb[1] = 32'h0000_0001; vc[1] = 0; es[1] = 32'h0001_0000; ec[1] = 0; eo[1] = 0;
        va[2] = 32'hFFFF_FFFF; vb[2] = 32'h0000_0000; vc[2] = 1; es[2] = 32'h0000_0000; ec[2] = 1; eo[2] = 0;
        va[3] = 32'h7FFF_FFFF; vb[3] = 32'h0000_0001; vc[3] = 0; es[3] = 32'h8000_0000; ec[3] = 0; eo[3] = 1;
        va[4] = 32'h8000_0000; vb[4] = 32'h8000_0000; vc[4] = 0; es[4] = 32'h0000_0000; ec[4] = 1; eo[4] = 1;
        va[5] = 32'h1234_5678; vb[5] = 32'h9ABC_DEF0; vc[5] = 0; es[5] = 32'hACF1_3568; ec[5] = 0; eo[5] = 0;
        for (int i = 0; i < 6; i++) begin
            start_and_wait(va[i], vb[i], vc[i], lat, to);
            checks++; if (to) begin errors++; $display("FAIL vec%0d_timeout got=no out_valid exp=out_valid", i); end
            checks++; if (lat != 2) begin errors++; $display("FAIL vec%0d_latency got=%0d exp=2", i, lat); end
            checks++; if (out_sum !== es[i]) begin errors++; $display("FAIL vec%0d_sum got=%h exp=%h", i, out_sum, es[i]); end
            checks++; if (out_cout !== ec[i]) begin errors++; $display("FAIL vec%0d_cout got=%b exp=%b", i, out_cout, ec[i]); end
            checks++; if (out_ovf !== eo[i]) begin errors++; $display("FAIL vec%0d_ovf got=%b exp=%b", i, out_ovf, eo[i]); end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL vec%0d_handshake got=%b exp=01", i, {out_valid, in_ready}); end
        end
    endtask

    task automatic test_slice_drive();
        in_valid = 1'b1; in_a = 32'hAAAA_5555; in_b = 32'h1111_2222; in_cin = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if ({add_a, add_b, add_cin} !== {16'h5555, 16'h2222, 1'b1}) begin
            errors++; $display("FAIL slice0_drive got=%h/%h/%b exp=5555/2222/1", add_a, add_b, add_cin); end
        step();
        checks++; if ({add_a, add_b, add_cin} !== {16'hAAAA, 16'h1111, 1'b0}) begin
            errors++; $display("FAIL slice1_drive got=%h/%h/%b exp=aaaa/1111/0", add_a, add_b, add_cin); end
        step();
        checks++; if (out_sum !== 32'hBBBB_7778) begin errors++; $display("FAIL slice_sum got=%h exp=bbbb7778", out_sum); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int   lat;
        logic to;
        logic bad_stable;
        logic bad_ready;
        bad_ready = 1'b0;
        in_valid = 1'b1; in_a = 32'h0000_0100; in_b = 32'h0000_0200; in_cin = 1'b0;
        step();
        // Keep in_valid high with different operands through RUN and DONE.
        in_a = 32'hDEAD_BEEF; in_b = 32'h0BAD_F00D;
        lat = 0;
        to = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (in_ready !== 1'b0) bad_ready = 1'b1;
            if (out_valid) begin to = 1'b0; break; end
            step();
        end
        checks++; if (to) begin errors++; $display("FAIL bp_timeout got=no out_valid exp=out_valid"); end
        bad_stable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (in_ready !== 1'b0) bad_ready = 1'b1;
            if (out_valid !== 1'b1 || out_sum !== 32'h0000_0300 || out_cout !== 1'b0 || out_ovf !== 1'b0)
                bad_stable = 1'b1;
        end
        checks++; if (bad_stable) begin errors++; $display("FAIL bp_stable got=%b/%h exp=1/00000300", out_valid, out_sum); end
        checks++; if (bad_ready) begin errors++; $display("FAIL bp_in_ready got=1 exp=0 while busy"); end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL bp_release got=%b exp=01", {out_valid, in_ready}); end
        // Back-to-back: accept immediately in the freshly returned IDLE cycle.
        start_and_wait(32'h0000_0003, 32'h0000_0004, 1'b0, lat, to);
        checks++; if (to || out_sum !== 32'h0000_0007) begin errors++; $display("FAIL b2b_sum got=%h exp=00000007", out_sum); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        int   lat;
        logic to;
        logic pulse;
        in_valid = 1'b1; in_a = 32'h0001_FFFF; in_b = 32'h0001_0001; in_cin = 1'b0;
        step();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL rst_mid_hs got=%b exp=01", {out_valid, in_ready}); end
        checks++; if (out_sum !== 32'h0) begin errors++; $display("FAIL rst_mid_sum got=%h exp=0", out_sum); end
        step();
        rst_n = 1'b1;
        pulse = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (out_valid !== 1'b0) pulse = 1'b1;
        end
        checks++; if (pulse) begin errors++; $display("FAIL rst_mid_pulse got=out_valid exp=none"); end
        start_and_wait(32'h0001_FFFF, 32'h0001_0001, 1'b0, lat, to);
        checks++; if (to || out_sum !== 32'h0003_0000) begin errors++; $display("FAIL rst_fresh_sum got=%h exp=00030000", out_sum); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
        #12;
        test_reset();
        rst_n = 1'b1;
        step();
        test_vectors();
        test_slice_drive();
        test_backpressure();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
